vmac_cfu: RTL and testbench
===========================

VMAC_CFU -- requirements
Module: vmac_cfu

Interface
REQ-001 SHALL have parameter ACC_WIDTH, default 32, accumulator width in bits; legal 16..32.
REQ-002 SHALL have parameter N_ACC, default 4, number of accumulator channels; power of two, 1..16.
REQ-003 SHALL have parameter BYTES_PER_CYCLE, default 1, int8 products summed per busy cycle; legal 1, 2, 4.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port cmd_valid  input  1  command offered.
REQ-007 SHALL have port cmd_ready  output  1  block can accept a command.
REQ-008 SHALL have port cmd_payload_function_id  input  10  [2:0] opcode, [6:3] channel index.
REQ-009 SHALL have port cmd_payload_inputs_0  input  32  operand A, four int8 lanes, lane 0 in [7:0].
REQ-010 SHALL have port cmd_payload_inputs_1  input  32  operand B, four int8 lanes, lane 0 in [7:0].
REQ-011 SHALL have port rsp_valid  output  1  response available.
REQ-012 SHALL have port rsp_ready  input  1  consumer accepts response.
REQ-013 SHALL have port rsp_payload_outputs_0  output  32  response data.

Function
REQ-014 SHALL implement three states: IDLE, BUSY, RESP.
REQ-015 SHALL drive cmd_ready high only in IDLE; a command is accepted on a rising edge with cmd_valid and cmd_ready both high, and opcode, channel and operands are registered at acceptance.
REQ-016 SHALL use channel = function_id[6:3] modulo N_ACC.
REQ-017 SHALL decode opcode 0 (CLEAR) as: acc[channel] <= 0; response 0; IDLE->RESP.
REQ-018 SHALL decode opcode 1 (MAC) as: IDLE->BUSY for exactly 4/BYTES_PER_CYCLE cycles, then acc[channel] <= acc[channel] + sum over lanes i of (A_i + offset) * B_i; response is the updated accumulator; BUSY->RESP.
REQ-019 SHALL decode opcode 2 (READ) as: response acc[channel]; IDLE->RESP; no state change.
REQ-020 SHALL decode opcode 3 (SETOFF) as: offset <= inputs_0[8:0], signed 9-bit; response 0; IDLE->RESP.
REQ-021 SHALL decode opcodes 4..7 as: response 0; no state change; IDLE->RESP.
REQ-022 SHALL perform all arithmetic signed: A_i and B_i sign-extended from 8 bits, each (A_i + offset) product 18 bits, lane sum 20 bits, then sign-extended to ACC_WIDTH.
REQ-023 SHALL hold rsp_valid high and rsp_payload_outputs_0 stable in RESP until rsp_ready is sampled high, then go to IDLE; there is no back-to-back acceptance in that same cycle.
REQ-024 SHALL sign-extend rsp_payload_outputs_0 from ACC_WIDTH to 32 bits.
REQ-025 SHALL keep rsp_valid low in IDLE and BUSY, and SHALL keep rsp_payload_outputs_0 at its last value when not in RESP.
REQ-026 SHALL give MAC a latency of 4/BYTES_PER_CYCLE + 1 cycles from acceptance to rsp_valid; all other opcodes 1 cycle.
REQ-027 SHALL ignore cmd_valid while in BUSY or RESP, with no state change.

Reset
REQ-028 SHALL, when reset is low on a rising clk edge, set state IDLE, every acc to 0, offset to 0, rsp_valid to 0 and rsp_payload_outputs_0 to 0; cmd_ready goes high on the first edge after reset deasserts.
REQ-029 SHALL, on reset asserted in BUSY or RESP, abort the operation: no accumulator update and no response.

Configuration
REQ-030 SHALL, with VMAC_SAT_EN defined, clamp the MAC accumulate result to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
REQ-031 SHALL, without VMAC_SAT_EN, wrap the MAC accumulate modulo 2^ACC_WIDTH.

Verification
REQ-032 SHALL verify basic MAC: CLEAR ch0; MAC A=0x01020304, B=0x01010101, offset 0 -> response 10; READ ch0 -> 10.
REQ-033 SHALL verify offset: SETOFF 128; MAC A=0x80808080, B=0x05050505 on ch1 -> response 0; SETOFF 0; MAC A=0xFFFFFFFF, B=0x02020202 -> response -8 (0xFFFFFFF8).
REQ-034 SHALL verify latency: for BYTES_PER_CYCLE in {1, 2, 4}, MAC with rsp_ready tied high -> rsp_valid exactly 5, 3, 2 cycles after acceptance; cmd_ready low throughout.
REQ-035 SHALL verify overflow: ACC_WIDTH=20, eight MACs A=B=0x80808080 on ch2 -> final response 524287 with VMAC_SAT_EN, -524288 without.
REQ-036 SHALL verify backpressure and reset: hold rsp_ready low 10 cycles -> rsp_valid and data stable and cmd_ready low; assert reset mid-BUSY -> READ of that channel returns its pre-command value of 0.
REQ-037 SHALL verify channel aliasing: N_ACC=4, MAC A=B=0x00000001 with channel 5 -> READ channel 1 returns 1; opcode 6 -> response 0 and no accumulator change.

Source files
------------

// File: rtl/vmac_cfu.sv
// vmac_cfu: int8 four-lane dot-product MAC unit with N_ACC accumulator channels.
// Optional build macro VMAC_SAT_EN: saturate MAC accumulation instead of wrapping.
module vmac_cfu #(
    parameter int unsigned ACC_WIDTH       = 32,
    parameter int unsigned N_ACC           = 4,
    parameter int unsigned BYTES_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [9:0]  cmd_payload_function_id,
    input  logic [31:0] cmd_payload_inputs_0,
    input  logic [31:0] cmd_payload_inputs_1,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_payload_outputs_0
);

    localparam int unsigned CH_W    = (N_ACC > 1) ? $clog2(N_ACC) : 1;
    localparam int unsigned N_BEATS = 4 / BYTES_PER_CYCLE;
    localparam int unsigned EXT_W   = 33 - ACC_WIDTH;

    localparam logic [2:0] OP_CLEAR  = 3'd0;
    localparam logic [2:0] OP_MAC    = 3'd1;
    localparam logic [2:0] OP_READ   = 3'd2;
    localparam logic [2:0] OP_SETOFF = 3'd3;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t               state_q, state_d;
    logic                 cmd_ready_q, cmd_ready_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [31:0]          rsp_data_q, rsp_data_d;
    logic [ACC_WIDTH-1:0] acc_q [N_ACC];
    logic [ACC_WIDTH-1:0] acc_d [N_ACC];
    logic [8:0]           offset_q, offset_d;
    logic [CH_W-1:0]      ch_q, ch_d;
    logic [31:0]          a_q, a_d;
    logic [31:0]          b_q, b_d;
    logic [19:0]          sum_q, sum_d;
    logic [1:0]           cnt_q, cnt_d;

    logic [2:0]           cmd_op;
    logic [CH_W-1:0]      cmd_ch;
    logic                 accept;
    logic                 unused_fid;

    logic [9:0]           lane_a;
    logic [17:0]          lane_p;
    logic [19:0]          part_c;
    logic [19:0]          lane_sum_c;
    logic [ACC_WIDTH-1:0] addend_c;
    logic [ACC_WIDTH:0]   total_c;
    logic [ACC_WIDTH-1:0] mac_res_c;

    function automatic logic [31:0] sext32(input logic [ACC_WIDTH-1:0] v);
        return 32'({{EXT_W{v[ACC_WIDTH-1]}}, v});
    endfunction

    assign cmd_op     = cmd_payload_function_id[2:0];
    assign cmd_ch     = CH_W'(cmd_payload_function_id[6:3] & 4'(N_ACC - 1));
    assign unused_fid = ^cmd_payload_function_id[9:7];
    assign accept     = cmd_valid && cmd_ready_q;

    // Partial dot product of the low BYTES_PER_CYCLE lanes; operands shift down each beat.
    always_comb begin
        part_c = '0;
        lane_a = '0;
        lane_p = '0;
        for (int j = 0; j < int'(BYTES_PER_CYCLE); j++) begin
            lane_a = {{2{a_q[8*j+7]}}, a_q[8*j +: 8]} + {offset_q[8], offset_q};
            lane_p = {{8{lane_a[9]}}, lane_a} * {{10{b_q[8*j+7]}}, b_q[8*j +: 8]};
            part_c = part_c + {{2{lane_p[17]}}, lane_p};
        end
    end

    assign lane_sum_c = sum_q + part_c;
    assign addend_c   = ACC_WIDTH'({{13{lane_sum_c[19]}}, lane_sum_c});
    assign total_c    = {acc_q[ch_q][ACC_WIDTH-1], acc_q[ch_q]}
                      + {addend_c[ACC_WIDTH-1], addend_c};

`ifdef VMAC_SAT_EN
    // Carry disagreeing with the sign bit means signed overflow; clamp toward its direction.
    always_comb begin
        mac_res_c = total_c[ACC_WIDTH-1:0];
        if (total_c[ACC_WIDTH] != total_c[ACC_WIDTH-1]) begin
            mac_res_c = total_c[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                           : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
    end
`else
    logic unused_carry;
    assign unused_carry = total_c[ACC_WIDTH];
    assign mac_res_c    = total_c[ACC_WIDTH-1:0];
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        cmd_ready_d = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        acc_d       = acc_q;
        offset_d    = offset_q;
        ch_d        = ch_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        cnt_d       = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    ch_d        = cmd_ch;
                    a_d         = cmd_payload_inputs_0;
                    b_d         = cmd_payload_inputs_1;
                    sum_d       = '0;
                    cnt_d       = '0;
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = '0;
                    case (cmd_op)
                        OP_CLEAR:  acc_d[cmd_ch] = '0;
                        OP_MAC: begin
                            state_d     = BUSY;
                            rsp_valid_d = 1'b0;
                            rsp_data_d  = rsp_data_q;
                        end
                        OP_READ:   rsp_data_d = sext32(acc_q[cmd_ch]);
                        OP_SETOFF: offset_d = cmd_payload_inputs_0[8:0];
                        default:   ;
                    endcase
                end
            end
            BUSY: begin
                sum_d = lane_sum_c;
                a_d   = a_q >> (8 * BYTES_PER_CYCLE);
                b_d   = b_q >> (8 * BYTES_PER_CYCLE);
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'(N_BEATS - 1)) begin
                    acc_d[ch_q] = mac_res_c;
                    rsp_data_d  = sext32(mac_res_c);
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        cmd_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            acc_q       <= '{default: '0};
            offset_q    <= '0;
            ch_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            acc_q       <= acc_d;
            offset_q    <= offset_d;
            ch_q        <= ch_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
        end
    end

    assign cmd_ready             = cmd_ready_q;
    assign rsp_valid             = rsp_valid_q;
    assign rsp_payload_outputs_0 = rsp_data_q;

endmodule

// File: tb/tb_vmac_cfu.sv
// Testbench for vmac_cfu: three instances (BYTES_PER_CYCLE 1/2/4, the last with ACC_WIDTH 20)
// checked against a behavioural accumulator model through an expected-response queue.
module tb_vmac_cfu;
    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  cmd_valid, cmd_ready, rsp_valid, rsp_ready;
    logic [9:0]  fid;
    logic [31:0] in0, in1;
    logic [31:0] rsp_data [NI];

    int          checks = 0;
    int          failures = 0;
    longint      macc [NI][4];
    int          moff [NI];
    int          accw [NI] = '{32, 32, 20};
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    vmac_cfu #(.ACC_WIDTH(32), .N_ACC(4), .BYTES_PER_CYCLE(1)) u_dut0 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_payload_function_id(fid), .cmd_payload_inputs_0(in0), .cmd_payload_inputs_1(in1),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_payload_outputs_0(rsp_data[0]));
    vmac_cfu #(.ACC_WIDTH(32), .N_ACC(4), .BYTES_PER_CYCLE(2)) u_dut1 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_payload_function_id(fid), .cmd_payload_inputs_0(in0), .cmd_payload_inputs_1(in1),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_payload_outputs_0(rsp_data[1]));
    vmac_cfu #(.ACC_WIDTH(20), .N_ACC(4), .BYTES_PER_CYCLE(4)) u_dut2 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid[2]), .cmd_ready(cmd_ready[2]),
        .cmd_payload_function_id(fid), .cmd_payload_inputs_0(in0), .cmd_payload_inputs_1(in1),
        .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]), .rsp_payload_outputs_0(rsp_data[2]));

    function automatic longint fold(input longint v, input int w);
        longint m, hi, r;
        m  = longint'(1) << w;
        hi = m / 2 - 1;
`ifdef VMAC_SAT_EN
        r = (v > hi) ? hi : ((v < -(m / 2)) ? -(m / 2) : v);
`else
        r = v % m;
        if (r < 0) r += m;
        if (r > hi) r -= m;
`endif
        return r;
    endfunction

    function automatic logic [31:0] model(input int k, input logic [2:0] op, input logic [3:0] ch,
                                          input logic [31:0] a, input logic [31:0] b);
        int c, ai, bi;
        longint s;
        logic [31:0] r;
        c = int'(ch) % 4;
        s = 0;
        r = '0;
        case (op)
            3'd0: macc[k][c] = 0;
            3'd1: begin
                for (int i = 0; i < 4; i++) begin
                    ai = $signed(a[8*i +: 8]);
                    bi = $signed(b[8*i +: 8]);
                    s += longint'((ai + moff[k]) * bi);
                end
                macc[k][c] = fold(macc[k][c] + s, accw[k]);
                r = 32'(macc[k][c]);
            end
            3'd2: r = 32'(macc[k][c]);
            3'd3: moff[k] = $signed(a[8:0]);
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < NI; k++) begin
            moff[k] = 0;
            for (int c = 0; c < 4; c++) macc[k][c] = 0;
        end
    endfunction

    // Drive one command, wait for its response with rsp_ready high, return data and latency.
    task automatic issue(input int k, input logic [2:0] op, input logic [3:0] ch,
                         input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] data, output int lat, output bit rdy_low, output bit tmo);
        int n;
        tmo = 1'b0; rdy_low = 1'b1; lat = 0; data = '0; n = 0;
        @(negedge clk);
        while (!cmd_ready[k] && n < 50) begin @(negedge clk); n++; end
        if (!cmd_ready[k]) begin tmo = 1'b1; return; end
        fid = {3'b000, ch, op}; in0 = a; in1 = b; cmd_valid[k] = 1'b1;
        @(negedge clk);
        cmd_valid[k] = 1'b0;
        lat = 1;
        while (!rsp_valid[k] && lat < 50) begin
            if (cmd_ready[k]) rdy_low = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid[k]) begin tmo = 1'b1; return; end
        if (cmd_ready[k]) rdy_low = 1'b0;
        data = rsp_data[k];
        @(posedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0; cmd_valid = '0; rsp_ready = '1; fid = '0; in0 = '0; in1 = '0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            checks++;
            if (cmd_ready[k] !== 1'b0) begin failures++; $display("FAIL reset_cmd_ready[%0d]: got %b expected 0", k, cmd_ready[k]); end
            checks++;
            if (rsp_valid[k] !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid[%0d]: got %b expected 0", k, rsp_valid[k]); end
            checks++;
            if (rsp_data[k] !== 32'h0) begin failures++; $display("FAIL reset_rsp_data[%0d]: got %h expected 0", k, rsp_data[k]); end
        end
        reset = 1'b1;
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            checks++;
            if (cmd_ready[k] !== 1'b1) begin failures++; $display("FAIL post_reset_ready[%0d]: got %b expected 1", k, cmd_ready[k]); end
        end
        model_reset();
    endtask

    task automatic test_basic_mac();
        logic [2:0]  ops  [3] = '{3'd0, 3'd1, 3'd2};
        logic [31:0] as   [3] = '{32'h0, 32'h01020304, 32'h0};
        logic [31:0] bs   [3] = '{32'h0, 32'h01010101, 32'h0};
        logic [31:0] exps [3] = '{32'd0, 32'd10, 32'd10};
        logic [31:0] got, e;
        int lat; bit rl, tmo;
        for (int i = 0; i < 3; i++) begin
            void'(model(0, ops[i], 4'd0, as[i], bs[i]));
            exp_q.push_back(exps[i]);
            issue(0, ops[i], 4'd0, as[i], bs[i], got, lat, rl, tmo);
            e = exp_q.pop_front();
            checks++;
            if (tmo || got !== e) begin failures++; $display("FAIL basic[%0d]: got %h expected %h timeout=%0d", i, got, e, tmo); end
        end
    endtask

    task automatic test_offset();
        logic [2:0]  ops  [4] = '{3'd3, 3'd1, 3'd3, 3'd1};
        logic [31:0] as   [4] = '{32'd128, 32'h80808080, 32'd0, 32'hFFFFFFFF};
        logic [31:0] bs   [4] = '{32'h0, 32'h05050505, 32'h0, 32'h02020202};
        logic [31:0] exps [4] = '{32'd0, 32'd0, 32'd0, 32'hFFFFFFF8};
        logic [31:0] got, e;
        int lat; bit rl, tmo;
        for (int i = 0; i < 4; i++) begin
            void'(model(0, ops[i], 4'd1, as[i], bs[i]));
            exp_q.push_back(exps[i]);
            issue(0, ops[i], 4'd1, as[i], bs[i], got, lat, rl, tmo);
            e = exp_q.pop_front();
            checks++;
            if (tmo || got !== e) begin failures++; $display("FAIL offset[%0d]: got %h expected %h timeout=%0d", i, got, e, tmo); end
        end
    endtask

    task automatic test_latency();
        int exp_lat [NI] = '{5, 3, 2};
        logic [31:0] got, e;
        int lat; bit rl, tmo;
        for (int k = 0; k < NI; k++) begin
            exp_q.push_back(model(k, 3'd1, 4'd3, 32'h01010101, 32'h01010101));
            issue(k, 3'd1, 4'd3, 32'h01010101, 32'h01010101, got, lat, rl, tmo);
            e = exp_q.pop_front();
            checks++;
            if (tmo || lat != exp_lat[k]) begin failures++; $display("FAIL latency[%0d]: got %0d expected %0d", k, lat, exp_lat[k]); end
            checks++;
            if (!rl) begin failures++; $display("FAIL busy_ready_low[%0d]: got cmd_ready high expected low", k); end
            checks++;
            if (got !== e) begin failures++; $display("FAIL latency_data[%0d]: got %h expected %h", k, got, e); end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] got, e;
        int lat; bit rl, tmo;
`ifdef VMAC_SAT_EN
        logic [31:0] final_exp = 32'h0007FFFF;
`else
        logic [31:0] final_exp = 32'hFFF80000;
`endif
        exp_q.push_back(model(2, 3'd0, 4'd2, 32'h0, 32'h0));
        issue(2, 3'd0, 4'd2, 32'h0, 32'h0, got, lat, rl, tmo);
        e = exp_q.pop_front();
        checks++;
        if (tmo || got !== e) begin failures++; $display("FAIL ovf_clear: got %h expected %h", got, e); end
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(model(2, 3'd1, 4'd2, 32'h80808080, 32'h80808080));
            issue(2, 3'd1, 4'd2, 32'h80808080, 32'h80808080, got, lat, rl, tmo);
            e = exp_q.pop_front();
            checks++;
            if (tmo || got !== e) begin failures++; $display("FAIL ovf_mac[%0d]: got %h expected %h", i, got, e); end
        end
        checks++;
        if (got !== final_exp) begin failures++; $display("FAIL ovf_final: got %h expected %h", got, final_exp); end
    endtask

    task automatic test_backpressure();
        logic [31:0] held, got, e;
        int n, bad, lat; bit rl, tmo;
        exp_q.push_back(model(0, 3'd2, 4'd0, 32'h0, 32'h0));
        n = 0;
        @(negedge clk);
        while (!cmd_ready[0] && n < 50) begin @(negedge clk); n++; end
        fid = {3'b000, 4'd0, 3'd2}; cmd_valid[0] = 1'b1; rsp_ready[0] = 1'b0;
        @(negedge clk);
        cmd_valid[0] = 1'b0;
        held = rsp_data[0];
        e = exp_q.pop_front();
        checks++;
        if (rsp_valid[0] !== 1'b1 || held !== e) begin failures++; $display("FAIL bp_first: valid %b data %h expected valid 1 data %h", rsp_valid[0], held, e); end
        // A CLEAR offered while the response is stalled must be ignored.
        fid = {3'b000, 4'd0, 3'd0}; cmd_valid[0] = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid[0] !== 1'b1 || rsp_data[0] !== held || cmd_ready[0] !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL bp_hold: got %0d unstable cycles expected 0", bad); end
        cmd_valid[0] = 1'b0; rsp_ready[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (rsp_valid[0] !== 1'b0 || cmd_ready[0] !== 1'b1) begin failures++; $display("FAIL bp_release: valid %b ready %b expected 0 1", rsp_valid[0], cmd_ready[0]); end
        exp_q.push_back(model(0, 3'd2, 4'd0, 32'h0, 32'h0));
        issue(0, 3'd2, 4'd0, 32'h0, 32'h0, got, lat, rl, tmo);
        e = exp_q.pop_front();
        checks++;
        if (tmo || got !== e) begin failures++; $display("FAIL bp_ignored_cmd: got %h expected %h", got, e); end
    endtask

    task automatic test_reset_busy();
        logic [31:0] got;
        int n, bad, lat; bit rl, tmo;
        n = 0;
        @(negedge clk);
        while (!cmd_ready[0] && n < 50) begin @(negedge clk); n++; end
        fid = {3'b000, 4'd2, 3'd1}; in0 = 32'h7F7F7F7F; in1 = 32'h7F7F7F7F; cmd_valid[0] = 1'b1;
        @(negedge clk);
        cmd_valid[0] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid[0] !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL rst_busy_no_rsp: got %0d valid cycles expected 0", bad); end
        issue(0, 3'd2, 4'd2, 32'h0, 32'h0, got, lat, rl, tmo);
        checks++;
        if (tmo || got !== 32'h0) begin failures++; $display("FAIL rst_busy_read: got %h expected 00000000", got); end
    endtask

    task automatic test_alias();
        logic [2:0]  ops  [4] = '{3'd1, 3'd2, 3'd6, 3'd2};
        logic [3:0]  chs  [4] = '{4'd5, 4'd1, 4'd1, 4'd1};
        logic [31:0] exps [4] = '{32'd1, 32'd1, 32'd0, 32'd1};
        logic [31:0] got, e;
        int lat; bit rl, tmo;
        for (int i = 0; i < 4; i++) begin
            void'(model(0, ops[i], chs[i], 32'h1, 32'h1));
            exp_q.push_back(exps[i]);
            issue(0, ops[i], chs[i], 32'h1, 32'h1, got, lat, rl, tmo);
            e = exp_q.pop_front();
            checks++;
            if (tmo || got !== e) begin failures++; $display("FAIL alias[%0d]: got %h expected %h", i, got, e); end
        end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [3:0]  ch;
        logic [31:0] a, b, got, e;
        int lat; bit rl, tmo;
        for (int i = 0; i < 30; i++) begin
            op = 3'($urandom_range(0, 7));
            ch = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom;
            exp_q.push_back(model(1, op, ch, a, b));
            issue(1, op, ch, a, b, got, lat, rl, tmo);
            e = exp_q.pop_front();
            checks++;
            if (tmo || got !== e) begin failures++; $display("FAIL random[%0d] op %0d ch %0d: got %h expected %h", i, op, ch, got, e); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_mac();
        test_offset();
        test_latency();
        test_overflow();
        test_backpressure();
        test_reset_busy();
        test_alias();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
